bsg_zynq_axi_read_arbiter: RTL and testbench
============================================

Name: bsg_zynq_axi_read_arbiter

Overview:
Shares the single AXI3 master read path to the PS memory port among num_req_p PL requesters, for example a host DMA engine and an accelerator memory bridge. It round-robin arbitrates AR requests and issues every burst with one fixed ARID so the slave returns data in order. A grant-order FIFO routes R beats back to the requester that owns each burst. The block sits between the requesters and the m00_axi AR/R channels of top_zynq.

Parameters:
num_req_p, 2, number of requesters (>=2)
addr_width_p, 32, AXI address width
data_width_p, 32, AXI data width
len_width_p, 4, ARLEN width (AXI3 bursts of 1..16 beats)
id_width_p, 6, ARID/RID width
els_p, 4, maximum outstanding bursts (grant-FIFO depth)
id_p, 0, fixed ARID driven on every request

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
s_araddr_i  in  num_req_p*addr_width_p  per-requester AR address; requester 0 in the low bits
s_arlen_i  in  num_req_p*len_width_p  per-requester burst length minus 1
s_arvalid_i  in  num_req_p  per-requester AR valid
s_arready_o  out  num_req_p  per-requester AR ready
s_rdata_o  out  data_width_p  R data, broadcast to all requesters
s_rresp_o  out  2  R response, broadcast
s_rlast_o  out  1  R last, broadcast
s_rvalid_o  out  num_req_p  per-requester R valid
s_rready_i  in  num_req_p  per-requester R ready
m_araddr_o  out  addr_width_p  to m00_axi_araddr
m_arlen_o  out  len_width_p  to m00_axi_arlen
m_arid_o  out  id_width_p  equals id_p
m_arvalid_o  out  1  AR valid
m_arready_i  in  1  AR ready
m_rdata_i  in  data_width_p  R data
m_rresp_i  in  2  R response
m_rlast_i  in  1  R last
m_rid_i  in  id_width_p  R id; checked only
m_rvalid_i  in  1  R valid
m_rready_o  out  1  R ready

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FIFO is empty.
  - Priority pointer points to requester 0.
  - State is IDLE.
  - m_arvalid_o, m_rready_o, s_arready_o and s_rvalid_o are all 0.
- AR FSM:
  - IDLE:
    - If the FIFO is not full and any s_arvalid_i is set, grant the first valid requester at or after the priority pointer (wrapping).
    - Drive m_arvalid_o=1 combinationally in the same cycle. m_araddr_o and m_arlen_o mux from the granted requester. s_arready_o[g]=m_arready_i; all other bits are 0.
    - If m_arready_i=0, register g and go to HOLD.
  - HOLD:
    - The grant is locked to the registered g. m_arvalid_o stays 1 and address/len stay stable.
    - Other requests are ignored until the AR handshake completes; then return to IDLE.
- On each AR handshake:
  - Push g into the FIFO.
  - Set the priority pointer to (g+1) mod num_req_p.
  - Zero added latency: AR is pass-through.
- FIFO full (els_p entries):
  - m_arvalid_o=0 and all s_arready_o=0.
  - A pop in the same cycle does not enable a push; there is no bypass, and the push happens the next cycle.
- R routing (h = FIFO head, valid only when the FIFO is non-empty):
  - s_rvalid_o[h]=m_rvalid_i.
  - m_rready_o=s_rready_i[h].
  - Data, resp and last are broadcast to all requesters.
  - An R handshake with m_rlast_i=1 pops the FIFO.
  - Push and pop in the same cycle are both performed.
- FIFO empty: m_rready_o=0 and all s_rvalid_o=0. A beat arriving while empty is a protocol error; the simulation assertion fires.
- m_rid_i != id_p while m_rvalid_i=1 triggers a simulation assertion. Routing is unaffected.
- Reset mid-burst: in-flight bursts are discarded. Requesters and the slave are reset in the same domain.

Test Plan:
- Req0 only: araddr 0x1000, arlen 3, m_arready=1 → m_araddr=0x1000, m_arid=0, s_arready[0]=1 the same cycle. 4 R beats go to s_rvalid[0] only; the FIFO is empty after rlast.
- Both requesters hold arvalid continuously with m_arready=1 → grants alternate 0,1,0,1 over 4 cycles; the FIFO order matches the grant order.
- Req0 granted, m_arready held 0 for 5 cycles, req1 asserts in cycle 2 → m_araddr stays req0's address for all 5 cycles, the grant stays 0, and req1 is granted the cycle after the handshake.
- els_p=4: issue 4 ARs with no R returned → the 5th AR sees m_arvalid=0 and s_arready=0. The rlast of the first burst pops the FIFO, and the 5th AR is accepted the next cycle.
- AR order req1 (len 1) then req0 (len 0), with s_rready[1]=0 for 3 cycles → m_rready=0 during those cycles. After release, 2 beats go to req1, then 1 beat goes to req0.
- areset pulsed while a burst has 2 beats remaining → all valid/ready outputs drop to 0 immediately; after release, the FIFO is empty and the grant restarts at req0.

Source files
------------

// File: rtl/bsg_zynq_axi_read_arbiter_if.sv
// AR/R bundle between the PL requesters, the read arbiter and the PS m00_axi port.
// The master modport is the arbiter view; slave is the requester/PS view.
interface bsg_zynq_axi_read_arbiter_if #(
    parameter int num_req_p    = 2,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int len_width_p  = 4,
    parameter int id_width_p   = 6
);
    logic [num_req_p*addr_width_p-1:0] s_araddr_i;
    logic [num_req_p*len_width_p-1:0]  s_arlen_i;
    logic [num_req_p-1:0]              s_arvalid_i;
    logic [num_req_p-1:0]              s_arready_o;
    logic [data_width_p-1:0]           s_rdata_o;
    logic [1:0]                        s_rresp_o;
    logic                              s_rlast_o;
    logic [num_req_p-1:0]              s_rvalid_o;
    logic [num_req_p-1:0]              s_rready_i;

    logic [addr_width_p-1:0]           m_araddr_o;
    logic [len_width_p-1:0]            m_arlen_o;
    logic [id_width_p-1:0]             m_arid_o;
    logic                              m_arvalid_o;
    logic                              m_arready_i;
    logic [data_width_p-1:0]           m_rdata_i;
    logic [1:0]                        m_rresp_i;
    logic                              m_rlast_i;
    logic [id_width_p-1:0]             m_rid_i;
    logic                              m_rvalid_i;
    logic                              m_rready_o;

    modport master (
        input  s_araddr_i, s_arlen_i, s_arvalid_i, s_rready_i,
        input  m_arready_i, m_rdata_i, m_rresp_i, m_rlast_i,
        input  m_rid_i, m_rvalid_i,
        output s_arready_o, s_rdata_o, s_rresp_o, s_rlast_o, s_rvalid_o,
        output m_araddr_o, m_arlen_o, m_arid_o, m_arvalid_o, m_rready_o
    );

    modport slave (
        output s_araddr_i, s_arlen_i, s_arvalid_i, s_rready_i,
        output m_arready_i, m_rdata_i, m_rresp_i, m_rlast_i,
        output m_rid_i, m_rvalid_i,
        input  s_arready_o, s_rdata_o, s_rresp_o, s_rlast_o, s_rvalid_o,
        input  m_araddr_o, m_arlen_o, m_arid_o, m_arvalid_o, m_rready_o
    );
endinterface

// File: rtl/bsg_zynq_axi_read_arbiter.sv
// Round-robin AXI3 read arbiter: one fixed ARID, in-order R beats routed
// back to their owner through a grant-order FIFO.
module bsg_zynq_axi_read_arbiter #(
    parameter int num_req_p    = 2,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int len_width_p  = 4,
    parameter int id_width_p   = 6,
    parameter int els_p        = 4,
    parameter int id_p         = 0
) (
    input  logic aclk,
    input  logic areset,
    bsg_zynq_axi_read_arbiter_if.master bus
);

    localparam int req_w_lp = $clog2(num_req_p);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    typedef logic [req_w_lp-1:0] req_t;
    typedef logic [ptr_w_lp-1:0] ptr_t;
    typedef logic [cnt_w_lp-1:0] cnt_t;

    localparam req_t last_req_lp  = req_t'(num_req_p - 1);
    localparam ptr_t last_slot_lp = ptr_t'(els_p - 1);
    localparam cnt_t full_cnt_lp  = cnt_t'(els_p);

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    state_e state_q, state_d;
    req_t   gnt_q, gnt_d;
    req_t   prio_q;
    req_t   pick, sel;
    logic   found;
    logic   ar_v, ar_hs;

    req_t   fifo_mem [els_p];
    ptr_t   wr_q, rd_q;
    cnt_t   cnt_q;
    req_t   head;
    logic   full, empty;
    logic   push, pop;
    logic   rready;

    logic [addr_width_p-1:0] addr_a [num_req_p];
    logic [len_width_p-1:0]  len_a  [num_req_p];

    always_comb begin
        for (int i = 0; i < num_req_p; i++) begin
            addr_a[i] = bus.s_araddr_i[i*addr_width_p +: addr_width_p];
            len_a[i]  = bus.s_arlen_i[i*len_width_p +: len_width_p];
        end
    end

    // Scan downward so the requester nearest the pointer is the last writer.
    always_comb begin
        int j;
        pick  = prio_q;
        found = 1'b0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            j = int'(prio_q) + i;
            if (j >= num_req_p) j = j - num_req_p;
            if (bus.s_arvalid_i[j]) begin
                pick  = req_t'(j);
                found = 1'b1;
            end
        end
    end

    assign full  = (cnt_q == full_cnt_lp);
    assign empty = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel     = pick;
        ar_v    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!full && found) begin
                    ar_v = 1'b1;
                    if (!bus.m_arready_i) begin
                        state_d = HOLD;
                        gnt_d   = pick;
                    end
                end
            end
            HOLD: begin
                sel  = gnt_q;
                ar_v = 1'b1;
                if (bus.m_arready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (areset) ar_v = 1'b0;
    end

    assign ar_hs = ar_v & bus.m_arready_i;
    assign push  = ar_hs;

    assign bus.m_arvalid_o = ar_v;
    assign bus.m_araddr_o  = addr_a[sel];
    assign bus.m_arlen_o   = len_a[sel];
    assign bus.m_arid_o    = id_width_p'(id_p);

    always_comb begin
        bus.s_arready_o      = '0;
        bus.s_arready_o[sel] = ar_hs;
    end

    assign head   = fifo_mem[rd_q];
    assign rready = !empty & bus.s_rready_i[head];
    assign pop    = bus.m_rvalid_i & rready & bus.m_rlast_i;

    assign bus.m_rready_o = rready;
    assign bus.s_rdata_o  = bus.m_rdata_i;
    assign bus.s_rresp_o  = bus.m_rresp_i;
    assign bus.s_rlast_o  = bus.m_rlast_i;

    always_comb begin
        bus.s_rvalid_o       = '0;
        bus.s_rvalid_o[head] = !empty & bus.m_rvalid_i;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            if (ar_hs) prio_q <= (sel == last_req_lp) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= (wr_q == last_slot_lp) ? '0 : wr_q + 1'b1;
            if (pop)  rd_q <= (rd_q == last_slot_lp) ? '0 : rd_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) fifo_mem[wr_q] <= sel;
    end

    // Beats with no owner or a foreign id mean the slave side is misbehaving.
    r_beat_owned: assert property (@(posedge aclk) disable iff (areset)
        !(bus.m_rvalid_i && empty));

    r_id_fixed: assert property (@(posedge aclk) disable iff (areset)
        !(bus.m_rvalid_i && (bus.m_rid_i != id_width_p'(id_p))));

endmodule

// File: tb/tb_bsg_zynq_axi_read_arbiter.sv
// Directed bench for the read arbiter: grant order, hold, fill limit,
// R routing and asynchronous reset.
module tb_bsg_zynq_axi_read_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int IW = 6;
    localparam int EL = 4;

    logic aclk = 1'b0;
    logic areset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 aclk = ~aclk;

    bsg_zynq_axi_read_arbiter_if #(
        .num_req_p(N), .addr_width_p(AW), .data_width_p(DW),
        .len_width_p(LW), .id_width_p(IW)
    ) bus ();

    bsg_zynq_axi_read_arbiter #(
        .num_req_p(N), .addr_width_p(AW), .data_width_p(DW),
        .len_width_p(LW), .id_width_p(IW), .els_p(EL), .id_p(0)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .bus(bus.master)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [AW-1:0] a,
                           input logic [LW-1:0] l);
        bus.s_araddr_i[r*AW +: AW] = a;
        bus.s_arlen_i[r*LW +: LW]  = l;
    endtask

    task automatic pulse_reset;
        areset = 1'b1;
        tick();
        areset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        areset          = 1'b1;
        bus.s_araddr_i  = '0;
        bus.s_arlen_i   = '0;
        bus.s_arvalid_i = '0;
        bus.s_rready_i  = '0;
        bus.m_arready_i = 1'b0;
        bus.m_rdata_i   = '0;
        bus.m_rresp_i   = '0;
        bus.m_rlast_i   = 1'b0;
        bus.m_rid_i     = '0;
        bus.m_rvalid_i  = 1'b0;
        #1;
        check("rst_arvalid", bus.m_arvalid_o, 0);
        check("rst_rready", bus.m_rready_o, 0);
        check("rst_arready", bus.s_arready_o, 0);
        check("rst_rvalid", bus.s_rvalid_o, 0);
        tick();
        tick();
        areset = 1'b0;

        // single requester, 4-beat burst
        set_req(0, 32'h1000, 4'd3);
        bus.s_arvalid_i = 2'b01;
        bus.m_arready_i = 1'b1;
        #1;
        check("t1_arvalid", bus.m_arvalid_o, 1);
        check("t1_araddr", bus.m_araddr_o, 32'h1000);
        check("t1_arlen", bus.m_arlen_o, 3);
        check("t1_arid", bus.m_arid_o, 0);
        check("t1_arready", bus.s_arready_o, 2'b01);
        tick();
        bus.s_arvalid_i = '0;
        bus.s_rready_i  = 2'b11;
        for (int b = 0; b < 4; b++) begin
            bus.m_rvalid_i = 1'b1;
            bus.m_rlast_i  = (b == 3);
            bus.m_rdata_i  = 32'hA0 + b;
            #1;
            check("t1_rvalid", bus.s_rvalid_o, 2'b01);
            check("t1_rready", bus.m_rready_o, 1);
            check("t1_rdata", bus.s_rdata_o, 32'hA0 + b);
            check("t1_rlast", bus.s_rlast_o, (b == 3));
            tick();
        end
        bus.m_rvalid_i = 1'b0;
        bus.m_rlast_i  = 1'b0;
        #1;
        check("t1_empty", bus.m_rready_o, 0);

        // alternation, then fill limit with no bypass
        pulse_reset();
        set_req(0, 32'h100, 4'd0);
        set_req(1, 32'h200, 4'd0);
        bus.s_arvalid_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_grant", bus.s_arready_o, (k % 2) ? 2'b10 : 2'b01);
            check("t2_araddr", bus.m_araddr_o, (k % 2) ? 32'h200 : 32'h100);
            tick();
        end
        #1;
        check("t4_full_arvalid", bus.m_arvalid_o, 0);
        check("t4_full_arready", bus.s_arready_o, 0);
        bus.m_rvalid_i = 1'b1;
        bus.m_rlast_i  = 1'b1;
        #1;
        check("t4_pop_rvalid", bus.s_rvalid_o, 2'b01);
        check("t4_no_bypass", bus.m_arvalid_o, 0);
        tick();
        bus.m_rvalid_i = 1'b0;
        #1;
        check("t4_refill_arvalid", bus.m_arvalid_o, 1);
        check("t4_refill_grant", bus.s_arready_o, 2'b01);
        tick();
        bus.s_arvalid_i = '0;
        bus.m_rvalid_i  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_order", bus.s_rvalid_o, (k % 2) ? 2'b01 : 2'b10);
            tick();
        end
        bus.m_rvalid_i = 1'b0;
        #1;
        check("t2_empty", bus.m_rready_o, 0);

        // grant locked while the slave stalls
        pulse_reset();
        set_req(0, 32'h2000, 4'd2);
        set_req(1, 32'h3000, 4'd0);
        bus.s_arvalid_i = 2'b01;
        bus.m_arready_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) bus.s_arvalid_i = 2'b11;
            #1;
            check("t3_arvalid", bus.m_arvalid_o, 1);
            check("t3_araddr", bus.m_araddr_o, 32'h2000);
            check("t3_arready", bus.s_arready_o, 2'b00);
            tick();
        end
        bus.m_arready_i = 1'b1;
        #1;
        check("t3_hs_grant", bus.s_arready_o, 2'b01);
        check("t3_hs_araddr", bus.m_araddr_o, 32'h2000);
        tick();
        bus.s_arvalid_i = 2'b10;
        #1;
        check("t3_next_grant", bus.s_arready_o, 2'b10);
        check("t3_next_araddr", bus.m_araddr_o, 32'h3000);
        tick();
        bus.s_arvalid_i = '0;
        bus.m_rvalid_i  = 1'b1;
        bus.m_rlast_i   = 1'b1;
        #1;
        check("t3_drain0", bus.s_rvalid_o, 2'b01);
        tick();
        check("t3_drain1", bus.s_rvalid_o, 2'b10);
        tick();
        bus.m_rvalid_i = 1'b0;

        // owner backpressure: req1 burst first, then req0
        set_req(1, 32'h4000, 4'd1);
        bus.s_arvalid_i = 2'b10;
        #1;
        check("t5_grant1", bus.s_arready_o, 2'b10);
        tick();
        set_req(0, 32'h5000, 4'd0);
        bus.s_arvalid_i = 2'b01;
        #1;
        check("t5_grant0", bus.s_arready_o, 2'b01);
        tick();
        bus.s_arvalid_i = '0;
        bus.m_rvalid_i  = 1'b1;
        bus.m_rlast_i   = 1'b0;
        bus.s_rready_i  = 2'b01;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t5_stall_rready", bus.m_rready_o, 0);
            check("t5_stall_rvalid", bus.s_rvalid_o, 2'b10);
            tick();
        end
        bus.s_rready_i = 2'b11;
        #1;
        check("t5_b0_rready", bus.m_rready_o, 1);
        check("t5_b0_rvalid", bus.s_rvalid_o, 2'b10);
        tick();
        bus.m_rlast_i = 1'b1;
        #1;
        check("t5_b1_rvalid", bus.s_rvalid_o, 2'b10);
        tick();
        check("t5_b2_rvalid", bus.s_rvalid_o, 2'b01);
        tick();
        bus.m_rvalid_i = 1'b0;
        bus.m_rlast_i  = 1'b0;
        #1;
        check("t5_empty", bus.m_rready_o, 0);

        // asynchronous reset mid-burst
        set_req(0, 32'h6000, 4'd3);
        bus.s_arvalid_i = 2'b01;
        tick();
        bus.s_arvalid_i = '0;
        bus.m_rvalid_i  = 1'b1;
        tick();
        tick();
        bus.s_arvalid_i = 2'b11;
        areset = 1'b1;
        #1;
        check("t6_arvalid", bus.m_arvalid_o, 0);
        check("t6_arready", bus.s_arready_o, 0);
        check("t6_rvalid", bus.s_rvalid_o, 0);
        check("t6_rready", bus.m_rready_o, 0);
        bus.m_rvalid_i = 1'b0;
        tick();
        areset = 1'b0;
        #1;
        check("t6_empty", bus.m_rready_o, 0);
        check("t6_arvalid_post", bus.m_arvalid_o, 1);
        check("t6_grant_post", bus.s_arready_o, 2'b01);
        tick();
        bus.s_arvalid_i = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
